riscv_aes_ld: RTL and testbench



---
 rtl/riscv_aes_pkg.sv | 16 +
 rtl/riscv_aes_ld.sv | 113 +++++++++++
 tb/tb_riscv_aes_ld.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_aes_pkg.sv
// Shared definitions for the AES accelerator memory front end.
package riscv_aes_pkg;

    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned AES_WORD_W      = 32;
    localparam int unsigned AES_NUM_WORDS   = 4;
    localparam int unsigned AES_WORD_STRIDE = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitR,
        StDone
    } aes_ld_state_t;

endpackage

// File: rtl/riscv_aes_ld.sv
// AES block loader: fetches four sequential words over a req/gnt/rvalid port,
// assembles them into one block and pulses data_valid_out, halting the core
// for the whole transfer.
// Optional build macro RISCV_AES_LD_BYTESWAP_EN: byte-reverse each word before
// storing it (AES big-endian byte order). Handshake timing is unchanged.
module riscv_aes_ld
    import riscv_aes_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = AES_WORD_W
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start_aes_ld,
    input  logic [ADDR_W-1:0]                            address_in,
    output logic                                         req_out,
    input  logic                                         gnt_in,
    output logic [ADDR_W-1:0]                            address_out,
    input  logic                                         rvalid_in,
    input  logic [WORD_W-1:0]                            rdata_in,
    output logic                                         halt_en_out,
    output logic                                         data_valid_out,
    output logic [(AES_BLOCK_W / AES_WORD_W) * WORD_W-1:0] data_out
);

    // Block keeps the AES word count regardless of the memory word width.
    localparam int unsigned BlockW = (AES_BLOCK_W / AES_WORD_W) * WORD_W;
    localparam int unsigned CntW   = $clog2(AES_NUM_WORDS);
    localparam logic [CntW-1:0] LastCnt = CntW'(AES_NUM_WORDS - 1);
    // Clears the sub-word address bits so the base is always word aligned.
    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(AES_WORD_STRIDE - 1);

    aes_ld_state_t     state_q;
    logic [CntW-1:0]   cnt_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              halt_q;
    logic              valid_q;
    logic [BlockW-1:0] data_q;
    logic [WORD_W-1:0] wr_word;

`ifdef RISCV_AES_LD_BYTESWAP_EN
    // Reverse byte order of the incoming word on the write path.
    always_comb begin
        wr_word = '0;
        for (int b = 0; b < int'(WORD_W / 8); b++) begin
            wr_word[8*b +: 8] = rdata_in[WORD_W-8-8*b +: 8];
        end
    end
`else
    assign wr_word = rdata_in;
`endif

    // Load sequencer; every output is a register so nothing glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_aes_ld) begin
                        addr_q  <= address_in & AlignMask;
                        cnt_q   <= '0;
                        halt_q  <= 1'b1;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    // req_out and address_out stay put until granted.
                    if (gnt_in) begin
                        req_q   <= 1'b0;
                        state_q <= StWaitR;
                    end
                end
                StWaitR: begin
                    if (rvalid_in) begin
                        data_q[cnt_q*WORD_W +: WORD_W] <= wr_word;
                        if (cnt_q == LastCnt) begin
                            valid_q <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            cnt_q   <= cnt_q + CntW'(1);
                            // Wraps modulo 2^ADDR_W past the top of memory.
                            addr_q  <= addr_q + ADDR_W'(AES_WORD_STRIDE);
                            req_q   <= 1'b1;
                            state_q <= StReq;
                        end
                    end
                end
                StDone: begin
                    valid_q <= 1'b0;
                    halt_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_out        = req_q;
    assign address_out    = addr_q;
    assign halt_en_out    = halt_q;
    assign data_valid_out = valid_q;
    assign data_out       = data_q;

endmodule

// File: tb/tb_riscv_aes_ld.sv
// Bench for riscv_aes_ld: stimulus pushes expected addresses, blocks and
// completion cycles into queues; a monitor pops and compares them.
module tb_riscv_aes_ld;

    logic         clk;
    logic         rst_n;
    logic         start_aes_ld;
    logic [31:0]  address_in;
    logic         req_out;
    logic         gnt_in;
    logic [31:0]  address_out;
    logic         rvalid_in;
    logic [31:0]  rdata_in;
    logic         halt_en_out;
    logic         data_valid_out;
    logic [127:0] data_out;

    riscv_aes_ld #(
        .ADDR_W(32),
        .WORD_W(32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_aes_ld  (start_aes_ld),
        .address_in    (address_in),
        .req_out       (req_out),
        .gnt_in        (gnt_in),
        .address_out   (address_out),
        .rvalid_in     (rvalid_in),
        .rdata_in      (rdata_in),
        .halt_en_out   (halt_en_out),
        .data_valid_out(data_valid_out),
        .data_out      (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  exp_addr_q[$];
    logic [127:0] exp_blk_q[$];
    int           exp_cyc_q[$];

    int           gd[4];
    int           rd[4];
    logic [31:0]  wds[4];
    logic [127:0] last_block = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory word as it should appear in its data_out lane.
    function automatic logic [31:0] lane_of(input logic [31:0] w);
`ifdef RISCV_AES_LD_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Runs one load from a negedge; returns at the negedge after halt falls
    // (or, for nwords < 4, with the DUT waiting on request nwords).
    task automatic do_load(input logic [31:0] addr, input int nwords, input bit spur);
        logic [31:0]  base;
        logic [127:0] blk;
        int           lat;
        int           s0;
        base = addr & 32'hFFFF_FFFC;
        blk  = last_block;
        lat  = 8;
        for (int k = 0; k < nwords; k++) begin
            exp_addr_q.push_back(base + 32'(4 * k));
            blk[k*32 +: 32] = lane_of(wds[k]);
            lat += gd[k] + rd[k];
        end
        if (nwords == 4) exp_blk_q.push_back(blk);
        start_aes_ld = 1'b1;
        address_in   = addr;
        @(negedge clk);
        start_aes_ld = 1'b0;
        address_in   = $urandom;
        s0 = cyc;
        if (nwords == 4) exp_cyc_q.push_back(s0 + lat);
        check("halt_at_start", 128'(halt_en_out), 128'(1));
        check("req_at_start", 128'(req_out), 128'(1));
        for (int k = 0; k < nwords; k++) begin
            for (int i = 0; i < gd[k]; i++) begin
                if (spur) begin
                    rvalid_in = 1'b1;
                    rdata_in  = $urandom;
                end
                @(negedge clk);
            end
            rvalid_in = 1'b0;
            gnt_in    = 1'b1;
            @(negedge clk);
            gnt_in = 1'b0;
            for (int i = 0; i < rd[k]; i++) begin
                if (spur) begin
                    gnt_in       = 1'($urandom_range(0, 1));
                    start_aes_ld = 1'b1;
                    address_in   = $urandom;
                end
                @(negedge clk);
                start_aes_ld = 1'b0;
                gnt_in       = 1'b0;
            end
            rvalid_in = 1'b1;
            rdata_in  = wds[k];
            @(negedge clk);
            rvalid_in = 1'b0;
            rdata_in  = $urandom;
            if (k == 0) check("lane0_written_rest_kept", data_out,
                              {last_block[127:32], lane_of(wds[0])});
        end
        if (nwords == 4) begin
            // DUT is in its valid cycle; a start here must be ignored.
            if (spur) begin
                start_aes_ld = 1'b1;
                address_in   = $urandom;
            end
            @(negedge clk);
            start_aes_ld = 1'b0;
            check("idle_req", 128'(req_out), 128'(0));
            check("idle_halt", 128'(halt_en_out), 128'(0));
            last_block = blk;
        end
    endtask

    task automatic set_delays(input int g0, input int g1, input int g2, input int g3,
                              input int r0, input int r1, input int r2, input int r3);
        gd = '{g0, g1, g2, g3};
        rd = '{r0, r1, r2, r3};
    endtask

    task automatic rand_words();
        for (int k = 0; k < 4; k++) wds[k] = $urandom;
    endtask

    // Scoreboard monitor: samples 1 time unit after each falling edge.
    initial begin : monitor
        bit          p_req;
        bit          p_gnt;
        bit          p_valid;
        logic [31:0] p_addr;
        p_req   = 1'b0;
        p_gnt   = 1'b0;
        p_valid = 1'b0;
        p_addr  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                p_req   = 1'b0;
                p_valid = 1'b0;
                continue;
            end
            if (p_req && !p_gnt) begin
                check("req_held", 128'(req_out), 128'(1));
                check("addr_held", 128'(address_out), 128'(p_addr));
            end
            if (p_valid) begin
                check("valid_one_cycle", 128'(data_valid_out), 128'(0));
                check("halt_falls_after_valid", 128'(halt_en_out), 128'(0));
            end
            if (req_out && gnt_in) begin
                check("addr_expected", 128'(exp_addr_q.size() != 0), 128'(1));
                if (exp_addr_q.size() != 0)
                    check("req_addr", 128'(address_out), 128'(exp_addr_q.pop_front()));
            end
            if (data_valid_out) begin
                check("halt_at_valid", 128'(halt_en_out), 128'(1));
                check("valid_expected", 128'(exp_blk_q.size() != 0), 128'(1));
                if (exp_blk_q.size() != 0) begin
                    check("block_data", data_out, exp_blk_q.pop_front());
                    check("valid_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
                end
            end
            p_req   = req_out;
            p_gnt   = gnt_in;
            p_addr  = address_out;
            p_valid = data_valid_out;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] a;
        rst_n        = 1'b0;
        start_aes_ld = 1'b0;
        address_in   = '0;
        gnt_in       = 1'b0;
        rvalid_in    = 1'b0;
        rdata_in     = '0;
        repeat (3) @(negedge clk);
        check("rst_req", 128'(req_out), 128'(0));
        check("rst_addr", 128'(address_out), 128'(0));
        check("rst_halt", 128'(halt_en_out), 128'(0));
        check("rst_valid", 128'(data_valid_out), 128'(0));
        check("rst_data", data_out, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Fast path, fixed data (byte-symmetric so both builds agree).
        wds = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        do_load(32'h0000_1000, 4, 1'b0);
        check("tp_block_const", data_out, 128'h44444444_33333333_22222222_11111111);

        // Grant held off 3 cycles on word 1.
        rand_words();
        set_delays(0, 3, 0, 0, 0, 0, 0, 0);
        do_load(32'h0000_1000, 4, 1'b0);

        // Address wrap and misaligned base.
        rand_words();
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        do_load(32'hFFFF_FFF8, 4, 1'b0);
        rand_words();
        do_load(32'h0000_1003, 4, 1'b0);

        // Spurious rvalid in REQ, gnt and start while busy.
        rand_words();
        set_delays(2, 1, 2, 1, 1, 2, 1, 2);
        do_load(32'h0000_4000, 4, 1'b1);

        // Reset with two words loaded, then a late rvalid.
        rand_words();
        set_delays(0, 0, 0, 0, 0, 0, 0, 0);
        do_load(32'h0000_2000, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", 128'(req_out), 128'(0));
        check("midrst_addr", 128'(address_out), 128'(0));
        check("midrst_halt", 128'(halt_en_out), 128'(0));
        check("midrst_valid", 128'(data_valid_out), 128'(0));
        check("midrst_data", data_out, 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rvalid_in = 1'b1;
        rdata_in  = $urandom;
        @(negedge clk);
        rvalid_in = 1'b0;
        check("late_rvalid_data", data_out, 128'(0));
        check("late_rvalid_req", 128'(req_out), 128'(0));
        check("late_rvalid_halt", 128'(halt_en_out), 128'(0));
        last_block = '0;
        rand_words();
        do_load(32'h0000_2000, 4, 1'b0);

        // Byte-order lane check.
        rand_words();
        wds[2] = 32'hAABBCCDD;
        do_load(32'h0000_3000, 4, 1'b0);
`ifdef RISCV_AES_LD_BYTESWAP_EN
        check("byteorder_lane2", 128'(data_out[95:64]), 128'(32'hDDCCBBAA));
`else
        check("byteorder_lane2", 128'(data_out[95:64]), 128'(32'hAABBCCDD));
`endif

        // Randomized loads.
        for (int n = 0; n < 30; n++) begin
            rand_words();
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            do_load(a, 4, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("addr_queue_drained", 128'(exp_addr_q.size()), 128'(0));
        check("blk_queue_drained", 128'(exp_blk_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
